// File: rtl/logic_serial_ctrl.sv
// rtl/logic_serial_ctrl.sv - bit-serial sequencer driving a shared 1-bit logic slice
// Accepts an operand pair, streams it LSB-first through the slice, and returns the assembled result.
module logic_serial_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [1:0]       op_sel,
  output logic             lu_a,
  output logic             lu_b,
  output logic [1:0]       lu_sel,
  input  logic             lu_e,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic             result_zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [1:0]       sel_q, sel_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    sel_d        = sel_q;
    cnt_d        = cnt_q;
    start_ready  = 1'b0;
    result_valid = 1'b0;
    lu_a         = 1'b0;
    lu_b         = 1'b0;
    lu_sel       = 2'b00;
    case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          sel_d   = op_sel;
          cnt_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        lu_a   = a_q[0];
        lu_b   = b_q[0];
        lu_sel = sel_q;
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        // Slice output enters at the MSB so bit i settles at position i after WIDTH shifts.
        res_d  = {lu_e, res_q[WIDTH-1:1]};
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        result_valid = 1'b1;
        if (result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign result      = res_q;
  assign result_zero = ~|res_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_logic_serial_ctrl.sv
// tb/tb_logic_serial_ctrl.sv - scoreboard bench for logic_serial_ctrl with a behavioural slice and reference model
module tb_logic_serial_ctrl;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_valid = 1'b0;
  logic             start_ready;
  logic [WIDTH-1:0] op_a = '0;
  logic [WIDTH-1:0] op_b = '0;
  logic [1:0]       op_sel = 2'b00;
  logic             lu_a, lu_b, lu_e;
  logic [1:0]       lu_sel;
  logic             result_valid;
  logic             result_ready = 1'b0;
  logic [WIDTH-1:0] result;
  logic             result_zero;
  logic             busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rmode = 0;
  logic [WIDTH-1:0] exp_q[$];
  int               acc_q[$];
  logic [WIDTH-1:0] cur_a, cur_b;
  logic [1:0]       cur_sel;
  int               run_k = 0;
  bit               seen = 0;
  logic [WIDTH-1:0] held;
  logic             held_zero;

  logic_serial_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .op_a(op_a), .op_b(op_b), .op_sel(op_sel),
    .lu_a(lu_a), .lu_b(lu_b), .lu_sel(lu_sel), .lu_e(lu_e),
    .result_valid(result_valid), .result_ready(result_ready),
    .result(result), .result_zero(result_zero), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    case (lu_sel)
      2'b00:   lu_e = lu_a & lu_b;
      2'b01:   lu_e = lu_a | lu_b;
      2'b10:   lu_e = lu_a ^ lu_b;
      default: lu_e = ~lu_a;
    endcase
  end

  function automatic logic [WIDTH-1:0] ref_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic [1:0] s);
    case (s)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~a;
    endcase
  endfunction

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       result_ready = ($urandom_range(0, 3) != 0);
      1:       result_ready = 1'b0;
      default: result_ready = 1'b1;
    endcase
  end

  // Monitor: slice drive, handshake decode, and scoreboard pop on result handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("start_ready_decode", WIDTH'(start_ready), WIDTH'(!busy));
      if (busy && !result_valid) begin
        if (run_k < WIDTH) begin
          chk("lu_a", WIDTH'(lu_a), WIDTH'(cur_a[run_k]));
          chk("lu_b", WIDTH'(lu_b), WIDTH'(cur_b[run_k]));
          chk("lu_sel", WIDTH'(lu_sel), WIDTH'(cur_sel));
        end else begin
          chk("run_length", WIDTH'(run_k), WIDTH'(WIDTH - 1));
        end
        run_k++;
      end else begin
        chk("lu_idle", WIDTH'({lu_a, lu_b, lu_sel}), '0);
      end
      if (result_valid) begin
        if (!seen) begin
          seen = 1;
          held = result;
          held_zero = result_zero;
          if (exp_q.size() == 0) begin
            chk("unexpected_result", WIDTH'(1), WIDTH'(0));
          end else begin
            chk("result", result, exp_q[0]);
            chk("result_zero", WIDTH'(result_zero), WIDTH'(exp_q[0] == '0));
            chk("latency", WIDTH'(cyc - acc_q[0]), WIDTH'(WIDTH + 1));
          end
        end else begin
          chk("result_stable", result, held);
          chk("zero_stable", WIDTH'(result_zero), WIDTH'(held_zero));
        end
        if (result_ready) begin
          seen = 0;
          if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
          end
        end
      end
    end
  end

  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [1:0] s);
    int n = 0;
    @(negedge clk);
    while (!start_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!start_ready) begin
      chk("start_ready_timeout", WIDTH'(0), WIDTH'(1));
      return;
    end
    op_a = a; op_b = b; op_sel = s; start_valid = 1'b1;
    exp_q.push_back(ref_op(a, b, s));
    acc_q.push_back(cyc);
    @(posedge clk);
    cur_a = a; cur_b = b; cur_sel = s; run_k = 0;
    #1;
    start_valid = 1'b0;
    op_a = $urandom; op_b = $urandom; op_sel = 2'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", WIDTH'(exp_q.size()), '0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_start_ready"}, WIDTH'(start_ready), WIDTH'(1));
    chk({tag, "_result_valid"}, WIDTH'(result_valid), WIDTH'(0));
    chk({tag, "_busy"}, WIDTH'(busy), WIDTH'(0));
    chk({tag, "_result"}, result, '0);
    chk({tag, "_result_zero"}, WIDTH'(result_zero), WIDTH'(1));
    chk({tag, "_lu"}, WIDTH'({lu_a, lu_b, lu_sel}), '0);
  endtask

  initial begin
    #3;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    issue(32'hF0F0F0F0, 32'h0FF00FF0, 2'b00);
    drain();
    issue(32'h12345678, 32'h80000001, 2'b01);
    issue(32'hFFFFFFFF, 32'hAAAAAAAA, 2'b10);
    drain();
    issue(32'h00000000, 32'hDEADBEEF, 2'b11);
    issue(32'hAAAAAAAA, 32'h55555555, 2'b00);
    issue(32'h00000005, 32'h00000000, 2'b01);
    drain();

    // Backpressure with an ignored start pulse while the result is held.
    rmode = 1;
    issue(32'h0F0F1234, 32'h00FF5678, 2'b10);
    for (int i = 0; i < 100 && !result_valid; i++) @(negedge clk);
    chk("bp_valid", WIDTH'(result_valid), WIDTH'(1));
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        op_a = $urandom; op_b = $urandom; start_valid = 1'b1;
      end else begin
        start_valid = 1'b0;
      end
      @(negedge clk);
      chk("bp_hold_valid", WIDTH'(result_valid), WIDTH'(1));
    end
    start_valid = 1'b0;
    rmode = 2;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("bp_released", WIDTH'(result_valid), WIDTH'(0));
    chk("bp_idle", WIDTH'(start_ready), WIDTH'(1));
    rmode = 0;
    drain();

    // Asynchronous reset in the middle of RUN.
    issue(32'h12345678, 32'h9ABCDEF0, 2'b00);
    repeat (16) @(negedge clk);
    chk("busy_before_rst", WIDTH'(busy), WIDTH'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    exp_q.delete();
    acc_q.delete();
    seen = 0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(32'h0000FFFF, 32'hFFFF0000, 2'b10);
    drain();

    for (int i = 0; i < 30; i++) begin
      logic [WIDTH-1:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (i % 5 == 0) rb = ~ra;
      issue(ra, rb, 2'($urandom_range(0, 3)));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
